// File: rtl/shared_add_arb_if.sv
// rtl/shared_add_arb_if.sv - requester/result handshake bundle for the shared adder arbiter
interface shared_add_arb_if #(
  parameter int N = 4,
  parameter int R = 4
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]   IN_reqValid;
  logic [R*N-1:0] IN_reqA;
  logic [R*N-1:0] IN_reqB;
  logic [R-1:0]   OUT_reqReady;
  logic           OUT_resValid;
  logic [N-1:0]   OUT_resSum;
  logic           OUT_resCarry;
  logic [IW-1:0]  OUT_resId;
  logic           IN_resReady;
  logic [15:0]    OUT_grantCnt;

  modport master (
    output IN_reqValid, IN_reqA, IN_reqB, IN_resReady,
    input  OUT_reqReady, OUT_resValid, OUT_resSum, OUT_resCarry, OUT_resId, OUT_grantCnt
  );

  modport slave (
    input  IN_reqValid, IN_reqA, IN_reqB, IN_resReady,
    output OUT_reqReady, OUT_resValid, OUT_resSum, OUT_resCarry, OUT_resId, OUT_grantCnt
  );
endinterface

// File: rtl/shared_add_arb.sv
// rtl/shared_add_arb.sv - round-robin arbiter feeding R requesters into one registered N-bit adder
module shared_add_arb #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic             clk,
  input  logic             rst,
  shared_add_arb_if.slave  bus
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic [IW-1:0] r_ptr;
  logic          r_res_valid;
  logic [N-1:0]  r_res_sum;
  logic          r_res_carry;
  logic [IW-1:0] r_res_id;
  logic [15:0]   r_grant_cnt;

  logic          w_free;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic          w_accept;
  logic [IW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic [N:0]    w_sum;
  logic [R-1:0]  w_ready;

  assign w_free = !r_res_valid || bus.IN_resReady;

  // Rotating search starting at r_ptr; idx carries one extra bit so the wrap works for any R.
  always_comb begin
    logic [IW:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int k = 0; k < R; k++) begin
      idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(R)) idx = idx - (IW+1)'(R);
      if (!w_found && bus.IN_reqValid[idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[IW-1:0];
      end
    end
  end

  // Reset gates the grant so nothing is handed out while the block is held.
  assign w_accept  = rst && w_free && w_found;
  assign w_ptr_nxt = (w_win == IW'(R-1)) ? '0 : w_win + IW'(1);

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < R; i++) begin
      if (w_accept && (w_win == IW'(i))) w_ready[i] = 1'b1;
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < R; i++) begin
      if (w_win == IW'(i)) begin
        w_a = bus.IN_reqA[i*N +: N];
        w_b = bus.IN_reqB[i*N +: N];
      end
    end
  end

  // The single shared adder.
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
      r_grant_cnt <= '0;
    end else if (w_accept) begin
      r_ptr       <= w_ptr_nxt;
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum[N-1:0];
      r_res_carry <= w_sum[N];
      r_res_id    <= w_win;
      if (r_grant_cnt != 16'hFFFF) r_grant_cnt <= r_grant_cnt + 16'd1;
    end else if (bus.IN_resReady) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.OUT_reqReady = w_ready;
  assign bus.OUT_resValid = r_res_valid;
  assign bus.OUT_resSum   = r_res_sum;
  assign bus.OUT_resCarry = r_res_carry;
  assign bus.OUT_resId    = r_res_id;
  assign bus.OUT_grantCnt = r_grant_cnt;
endmodule
